cbfp_out_reorder_stream: RTL and testbench



---
 rtl/cbfp_out_reorder_stream.sv | 166 ++++++++++++++++
 tb/tb_cbfp_out_reorder_stream.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_out_reorder_stream.sv
// Ping-pong frame buffer behind the final CBFP normalize stage.
// Streams each captured frame LANES samples per beat in natural order.
module cbfp_out_reorder_stream #(
  parameter int N      = 512,
  parameter int LOG2N  = 9,
  parameter int W      = 13,
  parameter int LANES  = 4,
  parameter int BITREV = 1,
  localparam int BW    = LOG2N - $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic signed [W-1:0] data_re_in [0:N-1],
  input  logic signed [W-1:0] data_im_in [0:N-1],
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re [0:LANES-1],
  output logic signed [W-1:0] out_im [0:LANES-1],
  output logic [BW-1:0]       out_beat,
  output logic                out_first,
  output logic                out_last,
  output logic                drop_pulse,
  output logic [7:0]          drop_count
);

  localparam logic [BW-1:0] LAST = BW'(N / LANES - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic signed [W-1:0] bank_re [0:1][0:N-1];
  logic signed [W-1:0] bank_im [0:1][0:N-1];

  logic [1:0]    full;
  logic [1:0]    full_nx;
  logic          wr_bank;
  logic          wr_nx;
  logic          rd_bank;
  logic          rd_nx;
  logic [BW-1:0] beat;
  logic [BW-1:0] beat_nx;
  logic [0:0]    state;
  logic [0:0]    state_nx;

  logic xfer;
  logic rel;
  logic cap;
  logic rej;

  // Natural output index k of lane j, mapped to its buffered position.
  function automatic logic [LOG2N-1:0] src_index(
    input logic [BW-1:0] b,
    input int            j
  );
    logic [LOG2N-1:0] k;
    logic [LOG2N-1:0] r;
    k = LOG2N'(int'(b) * LANES + j);
    r = k;
    if (BITREV != 0) begin
      for (int i = 0; i < LOG2N; i++) begin
        r[i] = k[LOG2N-1-i];
      end
    end
    return r;
  endfunction

  assign out_valid = (state == S_STREAM);
  assign xfer      = out_valid & out_ready;
  assign rel       = xfer & (beat == LAST);

  // A full write bank can still take a frame when it is being
  // released on this very edge; the new frame overwrites it.
  assign in_ready  = !full[wr_bank] | (rel & (rd_bank == wr_bank));
  assign cap       = valid_in & in_ready;
  assign rej       = valid_in & !in_ready;

  assign out_beat  = beat;
  assign out_first = out_valid & (beat == '0);
  assign out_last  = out_valid & (beat == LAST);

  // Next-state logic: release first, then capture so capture wins.
  always_comb begin
    full_nx  = full;
    wr_nx    = wr_bank;
    rd_nx    = rd_bank;
    beat_nx  = beat;
    state_nx = state;
    if (xfer) begin
      beat_nx = beat + BW'(1);
    end
    if (rel) begin
      full_nx[rd_bank] = 1'b0;
      rd_nx            = !rd_bank;
      beat_nx          = '0;
    end
    if (cap) begin
      full_nx[wr_bank] = 1'b1;
      wr_nx            = !wr_bank;
    end
    unique case (state)
      S_IDLE: begin
        state_nx = full_nx[rd_nx] ? S_STREAM : S_IDLE;
      end
      S_STREAM: begin
        if (rel) begin
          state_nx = full_nx[rd_nx] ? S_STREAM : S_IDLE;
        end
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      beat    <= '0;
      state   <= S_IDLE;
    end else begin
      full    <= full_nx;
      wr_bank <= wr_nx;
      rd_bank <= rd_nx;
      beat    <= beat_nx;
      state   <= state_nx;
    end
  end

  // Whole-frame capture; bank contents are never reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < N; i++) begin
        bank_re[wr_bank][i] <= data_re_in[i];
        bank_im[wr_bank][i] <= data_im_in[i];
      end
    end
  end

  // Rejected-frame strobe and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= rej;
      if (rej && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Beat mux from the read bank; zero while idle.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      out_re[j] = '0;
      out_im[j] = '0;
      if (out_valid) begin
        out_re[j] = bank_re[rd_bank][src_index(beat, j)];
        out_im[j] = bank_im[rd_bank][src_index(beat, j)];
      end
    end
  end

endmodule

// File: tb/tb_cbfp_out_reorder_stream.sv
// Bench for cbfp_out_reorder_stream: frame-queue reference model,
// one instance with bit reversal and one in straight order.
module tb_cbfp_out_reorder_stream;

  localparam int N  = 512;
  localparam int W  = 13;
  localparam int L  = 4;
  localparam int NB = N / L;
  localparam int BW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] fre [0:N-1];
  logic signed [W-1:0] fim [0:N-1];

  logic in_ready, out_valid, out_first, out_last, drop_pulse;
  logic signed [W-1:0] out_re [0:L-1];
  logic signed [W-1:0] out_im [0:L-1];
  logic [BW-1:0] out_beat;
  logic [7:0] drop_count;

  logic in_ready0, out_valid0, out_first0, out_last0, drop_pulse0;
  logic signed [W-1:0] out_re0 [0:L-1];
  logic signed [W-1:0] out_im0 [0:L-1];
  logic [BW-1:0] out_beat0;
  logic [7:0] drop_count0;

  cbfp_out_reorder_stream #(.BITREV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_re_in(fre), .data_im_in(fim),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_beat(out_beat), .out_first(out_first),
    .out_last(out_last), .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  cbfp_out_reorder_stream #(.BITREV(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .data_re_in(fre), .data_im_in(fim),
    .in_ready(in_ready0), .out_valid(out_valid0),
    .out_ready(out_ready),
    .out_re(out_re0), .out_im(out_im0),
    .out_beat(out_beat0), .out_first(out_first0),
    .out_last(out_last0), .drop_pulse(drop_pulse0),
    .drop_count(drop_count0)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted frame ids, beat position of head.
  logic signed [W-1:0] pool_re [0:15][0:N-1];
  logic signed [W-1:0] pool_im [0:15][0:N-1];
  int q[$];
  int pos = 0;
  int mdrop = 0;
  int mpulse = 0;
  int next_id = 0;
  int ncmp = 0;
  int nerr = 0;

  function automatic int brev(input int k);
    int r = 0;
    int x = k;
    repeat (9) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int kind);
    for (int i = 0; i < N; i++) begin
      if (kind == 0) begin
        fre[i] = W'(i);
        fim[i] = W'(-i);
      end else begin
        fre[i] = W'($urandom);
        fim[i] = W'($urandom);
      end
      pool_re[next_id][i] = fre[i];
      pool_im[next_id][i] = fim[i];
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos = 0;
    mdrop = 0;
    mpulse = 0;
  endtask

  task automatic check_outputs();
    int v;
    int h;
    int ir;
    int er, ei, er0, ei0;
    v  = (q.size() > 0) ? 1 : 0;
    h  = v ? q[0] : 0;
    ir = (q.size() < 2 || (out_ready && pos == NB - 1)) ? 1 : 0;
    chk("out_valid", out_valid, v);
    chk("out_valid_straight", out_valid0, v);
    chk("in_ready", in_ready, ir);
    chk("drop_pulse", drop_pulse, mpulse);
    chk("drop_count", drop_count, mdrop);
    chk("out_first", out_first, (v && pos == 0) ? 1 : 0);
    chk("out_last", out_last, (v && pos == NB - 1) ? 1 : 0);
    chk("out_beat", out_beat, v ? pos : 0);
    for (int j = 0; j < L; j++) begin
      er = 0; ei = 0; er0 = 0; ei0 = 0;
      if (v) begin
        er  = pool_re[h][brev(pos * L + j)];
        ei  = pool_im[h][brev(pos * L + j)];
        er0 = pool_re[h][pos * L + j];
        ei0 = pool_im[h][pos * L + j];
      end
      chk($sformatf("re_lane%0d", j), out_re[j], er);
      chk($sformatf("im_lane%0d", j), out_im[j], ei);
      chk($sformatf("re_straight_lane%0d", j), out_re0[j], er0);
      chk($sformatf("im_straight_lane%0d", j), out_im0[j], ei0);
    end
  endtask

  task automatic step();
    int xf;
    int acc;
    int vin;
    #1;
    check_outputs();
    vin = valid_in ? 1 : 0;
    xf  = (q.size() > 0 && out_ready) ? 1 : 0;
    acc = (q.size() < 2 || (xf && pos == NB - 1)) ? 1 : 0;
    @(posedge clk);
    if (xf != 0) begin
      pos++;
      if (pos == NB) begin
        void'(q.pop_front());
        pos = 0;
      end
    end
    mpulse = (vin != 0 && acc == 0) ? 1 : 0;
    if (mpulse != 0 && mdrop < 255) mdrop++;
    if (vin != 0 && acc != 0) begin
      q.push_back(next_id);
      next_id = (next_id + 1) % 16;
    end
    #1;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode, output int cycles);
    int c = 0;
    valid_in = 1'b0;
    while (q.size() > 0 && c < 2000) begin
      out_ready = (mode == 0 || c % 4 == 0 || c % 4 == 3);
      step();
      c++;
    end
    chk("drain_budget", q.size(), 0);
    cycles = c;
  endtask

  int cyc;
  int dsave;
  int guard;
  int exp_b0 [0:3];
  int exp_b1 [0:3];

  initial begin
    exp_b0 = '{0, 256, 128, 384};
    exp_b1 = '{64, 320, 192, 448};
    set_frame(0);

    // reset state
    #2;
    check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    // single ramp frame, always ready
    set_frame(0);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    for (int j = 0; j < L; j++) begin
      chk("beat0_re", out_re[j], exp_b0[j]);
      chk("beat0_im", out_im[j], -exp_b0[j]);
      chk("beat0_re_straight", out_re0[j], j);
    end
    step();
    for (int j = 0; j < L; j++) begin
      chk("beat1_re", out_re[j], exp_b1[j]);
      chk("beat1_re_straight", out_re0[j], 4 + j);
    end
    drain(0, cyc);
    chk("single_beats", cyc, NB - 1);
    step();

    // backpressure pattern on a random frame
    set_frame(1);
    valid_in = 1'b1;
    out_ready = 1'b1;
    step();
    drain(1, cyc);
    step();

    // three frames back to back with no ready
    out_ready = 1'b0;
    dsave = mdrop;
    set_frame(1);
    valid_in = 1'b1;
    step();
    set_frame(1);
    step();
    #1 chk("full_in_ready", in_ready, 0);
    set_frame(1);
    step();
    valid_in = 1'b0;
    chk("f3_drop_pulse", drop_pulse, 1);
    chk("f3_drop_count", drop_count, dsave + 1);
    step();
    drain(0, cyc);
    chk("two_frames_no_bubble", cyc, 2 * NB);
    step();

    // capture on the exact releasing edge
    out_ready = 1'b0;
    set_frame(1);
    valid_in = 1'b1;
    step();
    set_frame(1);
    step();
    valid_in = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (pos != NB - 1 && guard < 300) begin
      step();
      guard++;
    end
    chk("reach_beat127", pos, NB - 1);
    dsave = mdrop;
    set_frame(1);
    valid_in = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    step();
    valid_in = 1'b0;
    step();
    chk("release_no_drop", drop_count, dsave);
    drain(0, cyc);
    step();

    // reset mid-frame with a buffered frame
    out_ready = 1'b0;
    set_frame(1);
    valid_in = 1'b1;
    step();
    set_frame(1);
    step();
    valid_in = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (pos != 50 && guard < 300) begin
      step();
      guard++;
    end
    chk("reach_beat50", pos, 50);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_beat", out_beat, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop_count", drop_count, 0);
    for (int j = 0; j < L; j++) begin
      chk("rst_out_re", out_re[j], 0);
      chk("rst_out_im", out_im[j], 0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();

    // saturation of the drop counter
    out_ready = 1'b0;
    set_frame(1);
    valid_in = 1'b1;
    step();
    set_frame(1);
    step();
    repeat (260) step();
    valid_in = 1'b0;
    chk("drop_saturate", drop_count, 255);
    step();
    drain(0, cyc);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
